microwave_ctrl: RTL and testbench

- Top-level sequencer for the microwave simulator. Sits between the board inputs (buttons, keypad, door switch) and the countdown timer.
- Collects a 4-digit mm:ss entry from the keypad and presents it to the timer as binary min/sec.
- Issues single-cycle start/pause/stop pulses to the timer, monitors its done flag, and drives the magnetron, lamp and end-of-cook beeper.

---
 rtl/microwave_pkg.sv | 38 +++
 rtl/bcd_time_buf.sv | 74 +++++++
 rtl/edge_detector.sv | 23 ++
 rtl/microwave_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_microwave_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave controller: FSM state encoding,
// time limits and the BCD digit buffer layout.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_ARMING   = 3'd2,
        ST_COOKING  = 3'd3,
        ST_PAUSED   = 3'd4,
        ST_FINISHED = 3'd5
    } state_e;

    localparam int unsigned MAX_MIN     = 99;
    localparam int unsigned MAX_SEC     = 59;
    localparam int unsigned ADD_SEC     = 30;
    localparam int unsigned SEC_PER_MIN = 60;
    localparam int unsigned MAX_TOTAL   = MAX_MIN * SEC_PER_MIN + MAX_SEC;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned TIME_W  = 7;   // 0..99
    localparam int unsigned TOTAL_W = 13;  // 0..6029 before saturation

    // Keypad entry mm:ss, d3 is the most significant minute digit.
    typedef struct packed {
        logic [DIGIT_W-1:0] d3;
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
    } bcd_time_t;

    // Two BCD digits to binary 0..99.
    function automatic logic [TIME_W-1:0] bcd_pair(input logic [DIGIT_W-1:0] hi,
                                                    input logic [DIGIT_W-1:0] lo);
        return TIME_W'(hi) * TIME_W'(10) + TIME_W'(lo);
    endfunction

endpackage

// File: rtl/bcd_time_buf.sv
// Four-digit mm:ss keypad buffer with +30 s saturating add and registered
// binary min/sec conversion.
// Ports: clock, reset (async, active-high); shift_i/digit_i push a digit in
//        at d0; add30_i adds 30 s (saturating at 99:59); clear_i zeroes the
//        buffer (clear > add30 > shift); zero_c flags an all-zero buffer;
//        min_o/sec_o are the registered binary values (sec clamped to 59).
module bcd_time_buf
    import microwave_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               shift_i,
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               add30_i,
    input  logic               clear_i,
    output logic               zero_c,
    output logic [TIME_W-1:0]  min_o,
    output logic [TIME_W-1:0]  sec_o
);

    bcd_time_t           digits_q, digits_d;
    logic [TIME_W-1:0]   min_c, sec_raw_c, sec_c, add_min_c, add_sec_c;
    logic [TIME_W-1:0]   min_q, sec_q;
    logic [TOTAL_W-1:0]  total_c;

    // Binary view of the current buffer; seconds entries above 59 clamp.
    always_comb begin
        min_c     = bcd_pair(digits_q.d3, digits_q.d2);
        sec_raw_c = bcd_pair(digits_q.d1, digits_q.d0);
        sec_c     = (sec_raw_c > TIME_W'(MAX_SEC)) ? TIME_W'(MAX_SEC) : sec_raw_c;
    end

    // +30 s in total seconds, saturated, then split back to mm:ss.
    always_comb begin
        total_c = TOTAL_W'(min_c) * TOTAL_W'(SEC_PER_MIN) + TOTAL_W'(sec_c) + TOTAL_W'(ADD_SEC);
        if (total_c > TOTAL_W'(MAX_TOTAL)) begin
            total_c = TOTAL_W'(MAX_TOTAL);
        end
        add_min_c = TIME_W'(total_c / TOTAL_W'(SEC_PER_MIN));
        add_sec_c = TIME_W'(total_c % TOTAL_W'(SEC_PER_MIN));
    end

    // Buffer next-state.
    always_comb begin
        digits_d = digits_q;
        if (clear_i) begin
            digits_d = '0;
        end else if (add30_i) begin
            digits_d.d3 = DIGIT_W'(add_min_c / TIME_W'(10));
            digits_d.d2 = DIGIT_W'(add_min_c % TIME_W'(10));
            digits_d.d1 = DIGIT_W'(add_sec_c / TIME_W'(10));
            digits_d.d0 = DIGIT_W'(add_sec_c % TIME_W'(10));
        end else if (shift_i) begin
            digits_d = {digits_q.d2, digits_q.d1, digits_q.d0, digit_i};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits_q <= '0;
            min_q    <= '0;
            sec_q    <= '0;
        end else begin
            digits_q <= digits_d;
            min_q    <= min_c;
            sec_q    <= sec_c;
        end
    end

    assign zero_c = (digits_q == '0);
    assign min_o  = min_q;
    assign sec_o  = sec_q;

endmodule

// File: rtl/edge_detector.sv
// Rising-edge detector for a synchronous level input.
// Ports: clock, reset (async, active-high), sig_i level in,
//        rise_c combinational one-cycle pulse on a 0->1 transition.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sig_i,
    output logic rise_c
);

    logic sig_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_c = sig_i & ~sig_q;

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave sequencer: keypad entry, start/pause/stop handshake with the
// countdown timer, magnetron/lamp/beeper control.
// Ports: clock, reset (async, active-high); btn_start/btn_stop/btn_add30
//        button levels (edge-detected here); door_open level; key_valid +
//        key_digit keypad strobe; timer_done timer idle flag.
//        Outputs (all registered): tmr_start/tmr_pause/tmr_stop one-cycle
//        timer pulses, min/sec binary time, magnetron, lamp, beep, err
//        (arming timeout pulse), state (debug).
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned BEEP_CYCLES = 300_000_000,
    parameter int unsigned ARM_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_add30,
    input  logic              door_open,
    input  logic              key_valid,
    input  logic [3:0]        key_digit,
    input  logic              timer_done,
    output logic              tmr_start,
    output logic              tmr_pause,
    output logic              tmr_stop,
    output logic [6:0]        min,
    output logic [6:0]        sec,
    output logic              magnetron,
    output logic              lamp,
    output logic              beep,
    output logic              err,
    output logic [2:0]        state
);

    localparam int unsigned CNT_MAX = (BEEP_CYCLES > ARM_TIMEOUT) ? BEEP_CYCLES : ARM_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d, pause_q, pause_d, stop_q, stop_d;
    logic               err_q, err_d, stop_pend_q, stop_pend_d;
    logic               magnetron_q, magnetron_d, lamp_q, lamp_d, beep_q, beep_d;

    logic start_rise_c, stop_rise_c, add30_rise_c;
    logic stop_req_c, pulse_last_c, key_ok_c;
    logic shift_c, add30_c, clear_c, zero_c;

    edge_detector u_start_edge (.clock(clock), .reset(reset), .sig_i(btn_start), .rise_c(start_rise_c));
    edge_detector u_stop_edge  (.clock(clock), .reset(reset), .sig_i(btn_stop),  .rise_c(stop_rise_c));
    edge_detector u_add30_edge (.clock(clock), .reset(reset), .sig_i(btn_add30), .rise_c(add30_rise_c));

    bcd_time_buf u_time_buf (
        .clock   (clock),
        .reset   (reset),
        .shift_i (shift_c),
        .digit_i (key_digit),
        .add30_i (add30_c),
        .clear_i (clear_c),
        .zero_c  (zero_c),
        .min_o   (min),
        .sec_o   (sec)
    );

    // A timer pulse last cycle blocks any new pulse this cycle; a stop that
    // lands in that gap is remembered and served one cycle later.
    assign pulse_last_c = start_q | pause_q | stop_q;
    assign stop_req_c   = stop_rise_c | stop_pend_q;
    assign key_ok_c     = key_valid & (key_digit <= 4'd9);

    // Next-state and output decode; priority stop > door > start > add30 > key.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        pause_d     = 1'b0;
        stop_d      = 1'b0;
        err_d       = 1'b0;
        stop_pend_d = 1'b0;
        shift_c     = 1'b0;
        add30_c     = 1'b0;
        clear_c     = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (stop_req_c) begin
                    if (state_q == ST_ENTRY) begin
                        clear_c = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (start_rise_c) begin
                    if (!door_open && !zero_c && !pulse_last_c) begin
                        start_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ARMING;
                    end
                end else if (add30_rise_c) begin
                    add30_c = 1'b1;
                    state_d = ST_ENTRY;
                end else if (key_ok_c) begin
                    shift_c = 1'b1;
                    state_d = ST_ENTRY;
                end
            end
            ST_ARMING, ST_COOKING, ST_PAUSED: begin
                if (stop_req_c) begin
                    if (pulse_last_c) begin
                        stop_pend_d = 1'b1;
                    end else begin
                        stop_d  = 1'b1;
                        clear_c = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    case (state_q)
                        ST_ARMING: begin
                            if (!timer_done) begin
                                state_d = ST_COOKING;
                            end else if (cnt_q == CNT_W'(ARM_TIMEOUT - 1)) begin
                                stop_d  = 1'b1;
                                err_d   = 1'b1;
                                state_d = ST_ENTRY;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        ST_COOKING: begin
                            if (door_open) begin
                                if (!pulse_last_c) begin
                                    pause_d = 1'b1;
                                    state_d = ST_PAUSED;
                                end
                            end else if (timer_done) begin
                                cnt_d   = '0;
                                state_d = ST_FINISHED;
                            end
                        end
                        default: begin
                            if (start_rise_c && !door_open && !pulse_last_c) begin
                                start_d = 1'b1;
                                state_d = ST_COOKING;
                            end
                        end
                    endcase
                end
            end
            ST_FINISHED: begin
                if (stop_req_c || door_open || (cnt_q == CNT_W'(BEEP_CYCLES - 1))) begin
                    clear_c = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        magnetron_d = (state_d == ST_COOKING);
        beep_d      = (state_d == ST_FINISHED);
        lamp_d      = door_open || (state_d == ST_COOKING) || (state_d == ST_PAUSED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            stop_q      <= 1'b0;
            err_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            magnetron_q <= 1'b0;
            lamp_q      <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            pause_q     <= pause_d;
            stop_q      <= stop_d;
            err_q       <= err_d;
            stop_pend_q <= stop_pend_d;
            magnetron_q <= magnetron_d;
            lamp_q      <= lamp_d;
            beep_q      <= beep_d;
        end
    end

    assign tmr_start = start_q;
    assign tmr_pause = pause_q;
    assign tmr_stop  = stop_q;
    assign err       = err_q;
    assign magnetron = magnetron_q;
    assign lamp      = lamp_q;
    assign beep      = beep_q;
    assign state     = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Testbench for microwave_ctrl: a behavioural model (integer digits, total
// seconds, cycles-in-state) predicts every output after each clock edge; a
// compare process checks the DUT each cycle, and directed scenarios pin the
// model with hand-computed literals.
module tb_microwave_ctrl;

    localparam int BEEP = 10;
    localparam int ARM  = 16;

    localparam int S_IDLE = 0, S_ENTRY = 1, S_ARMING = 2, S_COOKING = 3,
                   S_PAUSED = 4, S_FINISHED = 5;

    logic       clock, reset;
    logic       btn_start, btn_stop, btn_add30, door_open, key_valid, timer_done;
    logic [3:0] key_digit;
    logic       tmr_start, tmr_pause, tmr_stop, magnetron, lamp, beep, err;
    logic [6:0] min, sec;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    microwave_ctrl #(.BEEP_CYCLES(BEEP), .ARM_TIMEOUT(ARM)) dut (
        .clock(clock), .reset(reset),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_add30(btn_add30),
        .door_open(door_open), .key_valid(key_valid), .key_digit(key_digit),
        .timer_done(timer_done),
        .tmr_start(tmr_start), .tmr_pause(tmr_pause), .tmr_stop(tmr_stop),
        .min(min), .sec(sec), .magnetron(magnetron), .lamp(lamp),
        .beep(beep), .err(err), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state = S_IDLE;
    int m_age   = 0;
    int m_d[4]  = '{0, 0, 0, 0};   // m_d[3] = tens of minutes
    bit m_last_pulse = 0;
    bit p_start = 0, p_stop = 0, p_add = 0;
    int e_state = 0, e_min = 0, e_sec = 0;
    bit e_start = 0, e_pause = 0, e_stop = 0, e_err = 0, e_mag = 0, e_lamp = 0, e_beep = 0;

    function automatic int cur_min();
        return 10 * m_d[3] + m_d[2];
    endfunction

    function automatic int cur_sec();
        int s;
        s = 10 * m_d[1] + m_d[0];
        return (s > 59) ? 59 : s;
    endfunction

    task automatic set_time(input int total);
        int mm, ss;
        mm = total / 60;
        ss = total % 60;
        m_d[3] = mm / 10; m_d[2] = mm % 10;
        m_d[1] = ss / 10; m_d[0] = ss % 10;
    endtask

    always @(posedge clock) begin : model
        int nxt;
        bit ev_start, ev_stop, ev_add;
        if (reset) begin
            m_state = S_IDLE; m_age = 0; m_d = '{0, 0, 0, 0}; m_last_pulse = 0;
            p_start = 0; p_stop = 0; p_add = 0;
            e_state = 0; e_min = 0; e_sec = 0;
            e_start = 0; e_pause = 0; e_stop = 0; e_err = 0;
            e_mag = 0; e_lamp = 0; e_beep = 0;
        end else begin
            ev_start = btn_start && !p_start;
            ev_stop  = btn_stop && !p_stop;
            ev_add   = btn_add30 && !p_add;
            p_start = btn_start; p_stop = btn_stop; p_add = btn_add30;
            e_start = 0; e_pause = 0; e_stop = 0; e_err = 0;
            e_min = cur_min();
            e_sec = cur_sec();
            nxt = m_state;
            case (m_state)
                S_IDLE, S_ENTRY: begin
                    if (ev_stop) begin
                        if (m_state == S_ENTRY) begin
                            set_time(0); nxt = S_IDLE;
                        end
                    end else if (ev_start) begin
                        if (!door_open && (cur_min() + cur_sec() + m_d[1] + m_d[0] != 0) && !m_last_pulse) begin
                            e_start = 1; nxt = S_ARMING;
                        end
                    end else if (ev_add) begin
                        set_time((cur_min() * 60 + cur_sec() + 30 > 5999) ? 5999 : cur_min() * 60 + cur_sec() + 30);
                        nxt = S_ENTRY;
                    end else if (key_valid && key_digit <= 9) begin
                        m_d[3] = m_d[2]; m_d[2] = m_d[1]; m_d[1] = m_d[0]; m_d[0] = int'(key_digit);
                        nxt = S_ENTRY;
                    end
                end
                S_ARMING, S_COOKING, S_PAUSED: begin
                    if (ev_stop) begin
                        e_stop = 1; set_time(0); nxt = S_IDLE;
                    end else if (m_state == S_ARMING) begin
                        if (!timer_done) nxt = S_COOKING;
                        else if (m_age == ARM - 1) begin
                            e_stop = 1; e_err = 1; nxt = S_ENTRY;
                        end
                    end else if (m_state == S_COOKING) begin
                        if (door_open) begin
                            if (!m_last_pulse) begin e_pause = 1; nxt = S_PAUSED; end
                        end else if (timer_done) nxt = S_FINISHED;
                    end else if (ev_start && !door_open && !m_last_pulse) begin
                        e_start = 1; nxt = S_COOKING;
                    end
                end
                S_FINISHED: begin
                    if (ev_stop || door_open || m_age == BEEP - 1) begin
                        set_time(0); nxt = S_IDLE;
                    end
                end
                default: nxt = S_IDLE;
            endcase
            m_age = (nxt == m_state) ? m_age + 1 : 0;
            m_state = nxt;
            m_last_pulse = e_start || e_pause || e_stop;
            e_state = nxt;
            e_mag   = (nxt == S_COOKING);
            e_beep  = (nxt == S_FINISHED);
            e_lamp  = door_open || nxt == S_COOKING || nxt == S_PAUSED;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clock) begin
        #1;
        check("state", int'(state), e_state);
        check("min", int'(min), e_min);
        check("sec", int'(sec), e_sec);
        check("tmr_start", int'(tmr_start), int'(e_start));
        check("tmr_pause", int'(tmr_pause), int'(e_pause));
        check("tmr_stop", int'(tmr_stop), int'(e_stop));
        check("err", int'(err), int'(e_err));
        check("magnetron", int'(magnetron), int'(e_mag));
        check("lamp", int'(lamp), int'(e_lamp));
        check("beep", int'(beep), int'(e_beep));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic key(input int dg);
        @(negedge clock); key_valid = 1'b1; key_digit = 4'(dg);
        @(negedge clock); key_valid = 1'b0;
    endtask

    task automatic press(input int which);
        @(negedge clock);
        if (which == 0) btn_start = 1'b1;
        else if (which == 1) btn_stop = 1'b1;
        else btn_add30 = 1'b1;
        @(negedge clock);
        btn_start = 1'b0; btn_stop = 1'b0; btn_add30 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset = 1'b1;
        btn_start = 0; btn_stop = 0; btn_add30 = 0; door_open = 0;
        key_valid = 0; key_digit = 4'd0; timer_done = 1'b1;
        tick(3);
        check("rst_state", int'(state), 0);
        check("rst_min_sec", int'(min) + int'(sec), 0);
        check("rst_outs", int'({tmr_start, tmr_pause, tmr_stop, err, magnetron, lamp, beep}), 0);
        reset = 1'b0;
        tick(1);

        // Entry 12:34 and start.
        key(1); key(2); key(3); key(4); tick(1);
        check("entry_min", int'(min), 12);
        check("entry_sec", int'(sec), 34);
        check("entry_state", int'(state), S_ENTRY);
        press(0);
        check("start_pulse", int'(tmr_start), 1);
        check("arming_state", int'(state), S_ARMING);
        timer_done = 1'b0;
        tick(1);
        check("cook_state", int'(state), S_COOKING);
        check("cook_mag", int'(magnetron), 1);

        // Door pause and resume.
        door_open = 1'b1;
        tick(1);
        check("pause_pulse", int'(tmr_pause), 1);
        check("paused_mag_lamp", int'({magnetron, lamp}), 1);
        press(0);
        check("door_open_start", int'(tmr_start), 0);
        door_open = 1'b0;
        tick(2);
        check("paused_lamp", int'(lamp), 1);
        press(0);
        check("resume_pulse", int'(tmr_start), 1);
        check("resume_state", int'(state), S_COOKING);

        // Finish and beep length.
        tick(1);
        timer_done = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (beep) cnt++;
            if (state == 3'(S_IDLE)) break;
        end
        check("beep_cycles", cnt, BEEP);
        tick(1);
        check("finish_clear", int'(min) * 100 + int'(sec), 0);

        // Seconds clamp, bad digit, stop clear.
        key(0); key(0); key(7); key(5); key(12); tick(1);
        check("clamp_sec", int'(sec), 59);
        check("clamp_min", int'(min), 0);
        press(1); tick(1);
        check("stop_clear_state", int'(state), S_IDLE);
        check("stop_clear_sec", int'(sec), 0);

        // add30 from 00:00 three times, then saturation from 99:45.
        press(2); press(2); press(2); tick(1);
        check("add30_min", int'(min), 1);
        check("add30_sec", int'(sec), 30);
        press(1);
        key(9); key(9); key(4); key(5);
        press(2); tick(1);
        check("sat_min", int'(min), 99);
        check("sat_sec", int'(sec), 59);

        // Arming timeout with timer_done stuck high.
        press(0);
        check("arm_start", int'(tmr_start), 1);
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            cnt = k;
            if (err) break;
        end
        check("timeout_cycles", cnt, ARM);
        check("timeout_stop", int'(tmr_stop), 1);
        check("timeout_state", int'(state), S_ENTRY);
        check("timeout_keep", int'(min) * 100 + int'(sec), 9959);
        press(1); tick(1);
        check("idle_after_stop", int'(state), S_IDLE);

        // Start rejected at 00:00; start+stop together in ENTRY.
        press(0);
        check("zero_start", int'({tmr_start, state}), 0);
        key(5);
        @(negedge clock); btn_start = 1'b1; btn_stop = 1'b1;
        @(negedge clock); btn_start = 1'b0; btn_stop = 1'b0;
        check("start_stop_state", int'(state), S_IDLE);
        check("start_stop_pulse", int'(tmr_start), 0);

        // Asynchronous reset mid-cook.
        key(1); press(0);
        timer_done = 1'b0;
        tick(1);
        check("pre_reset_mag", int'(magnetron), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_outs", int'({tmr_start, tmr_pause, tmr_stop, err, magnetron, lamp, beep}), 0);
        check("async_rst_state", int'(state), 0);
        check("async_rst_time", int'(min) + int'(sec), 0);
        @(negedge clock); reset = 1'b0; timer_done = 1'b1;
        tick(2);
        check("post_reset_state", int'(state), S_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
